hazard_scoreboard: RTL and testbench

Parametrised hazard detection for the 5-stage pipeline, replacing the purely combinational compare-against-ID/EX scheme. It keeps a per-register countdown scoreboard of in-flight writes, so load-use, branch-in-ID and store-data hazards are resolved by latency class rather than by hard-wired stage compares. Memory-latency back-pressure is handled through a freeze input, and the block keeps a stall performance counter. It sits beside the ID stage and drives the PC/IF_ID hold and the ID/EX bubble.

---
 rtl/hazard_scoreboard_if.sv | 40 ++++
 rtl/hazard_scoreboard.sv | 122 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundles the ID-stage decode information and pipeline control outputs
// exchanged between the pipeline datapath and the hazard scoreboard.
//   master : pipeline side (drives ID_* / Flush / MemStall, reads controls)
//   slave  : scoreboard side (reads ID_* / Flush / MemStall, drives
//            Stall / Freeze / StallCount)
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
   parameter int REG_ADDR_W = 5,
   parameter int STAT_W     = 32
);
   logic                  ID_Valid;
   logic [REG_ADDR_W-1:0] ID_rs;
   logic [REG_ADDR_W-1:0] ID_rt;
   logic                  ID_UsesRs;
   logic                  ID_UsesRt;
   logic                  ID_Branch;
   logic                  ID_MemWrite;
   logic                  ID_RegWrite;
   logic                  ID_MemRead;
   logic [REG_ADDR_W-1:0] ID_Dest;
   logic                  Flush;
   logic                  MemStall;
   logic                  Stall;
   logic                  Freeze;
   logic [STAT_W-1:0]     StallCount;

   modport master (
      output ID_Valid, ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_Branch,
             ID_MemWrite, ID_RegWrite, ID_MemRead, ID_Dest, Flush, MemStall,
      input  Stall, Freeze, StallCount
   );

   modport slave (
      input  ID_Valid, ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_Branch,
             ID_MemWrite, ID_RegWrite, ID_MemRead, ID_Dest, Flush, MemStall,
      output Stall, Freeze, StallCount
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Per-register countdown scoreboard for a 5-stage pipeline. Each entry holds
// the number of cycles until the pending write to that register can be
// forwarded to a tolerance-0 consumer. The ID-stage instruction stalls when
// any source it reads is further away than its consumer class tolerates.
// Ports:
//   Clk  - rising-edge clock
//   Rst  - synchronous active-high reset (clears scoreboard and counter)
//   bus  - slave side of hazard_scoreboard_if:
//          in : ID_Valid, ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_Branch,
//               ID_MemWrite, ID_RegWrite, ID_MemRead, ID_Dest, Flush, MemStall
//          out: Stall (hold PC/IF_ID, bubble ID_EX), Freeze (= MemStall),
//               StallCount (saturating count of stalled cycles)
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int ALU_LAT    = 1,
   parameter int LOAD_LAT   = 2,
   parameter int TOL_ALU    = 1,
   parameter int TOL_STORE  = 2,
   parameter int TOL_BRANCH = 0,
   parameter int CNT_W      = 2,
   parameter int STAT_W     = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   hazard_scoreboard_if.slave bus
);

   localparam int NREG = 1 << REG_ADDR_W;

   // Counters must be able to hold the largest latency that gets loaded.
   if ((LOAD_LAT >= (1 << CNT_W)) || (ALU_LAT >= (1 << CNT_W))) begin : g_param_check
      $error("hazard_scoreboard: CNT_W=%0d cannot hold ALU_LAT=%0d / LOAD_LAT=%0d",
             CNT_W, ALU_LAT, LOAD_LAT);
   end

   localparam logic [31:0]      TOL_ALU_C    = 32'(TOL_ALU);
   localparam logic [31:0]      TOL_STORE_C  = 32'(TOL_STORE);
   localparam logic [31:0]      TOL_BRANCH_C = 32'(TOL_BRANCH);
   localparam logic [CNT_W-1:0] ALU_LAT_C    = CNT_W'(ALU_LAT);
   localparam logic [CNT_W-1:0] LOAD_LAT_C   = CNT_W'(LOAD_LAT);

   logic [CNT_W-1:0]  cnt_reg  [NREG];
   logic [CNT_W-1:0]  cnt_next [NREG];
   logic [STAT_W-1:0] stat_reg;

   logic [31:0] tol_rs;
   logic [31:0] tol_rt;
   logic [31:0] cnt_rs;
   logic [31:0] cnt_rt;
   logic        slot_live;
   logic        hazard;
   logic        stall;
   logic        issue;
   logic [CNT_W-1:0] load_val;

   // Consumer-class tolerance: branches/jr compare in ID, store data is only
   // needed at MEM, everything else is forwarded into EX.
   always_comb begin
      tol_rs = TOL_ALU_C;
      tol_rt = TOL_ALU_C;
      if (bus.ID_Branch) begin
         tol_rs = TOL_BRANCH_C;
         tol_rt = TOL_BRANCH_C;
      end else if (bus.ID_MemWrite) begin
         tol_rt = TOL_STORE_C;
      end
   end

   assign cnt_rs = 32'(cnt_reg[bus.ID_rs]);
   assign cnt_rt = 32'(cnt_reg[bus.ID_rt]);

   assign slot_live = bus.ID_Valid & ~bus.Flush;
   assign hazard    = slot_live &
                      ((bus.ID_UsesRs & (cnt_rs > tol_rs)) |
                       (bus.ID_UsesRt & (cnt_rt > tol_rt)));
   // Stall is masked while reset is held so the controls are clean before the
   // scoreboard has been cleared.
   assign stall     = hazard & ~bus.MemStall & ~Rst;
   assign issue     = slot_live & ~stall & ~bus.MemStall & bus.ID_RegWrite &
                      (bus.ID_Dest != '0);
   assign load_val  = bus.ID_MemRead ? LOAD_LAT_C : ALU_LAT_C;

   // Next value per entry. r0 never tracks a write. A fresh issue overrides
   // the decrement (later writer wins, no max). A stalled cycle still counts
   // down because the bubble lets older instructions advance.
   for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
      if (gi == 0) begin : g_zero
         assign cnt_next[gi] = '0;
      end else begin : g_live
         always_comb begin
            cnt_next[gi] = cnt_reg[gi];
            if (!bus.MemStall) begin
               if (issue && (bus.ID_Dest == REG_ADDR_W'(gi)))
                  cnt_next[gi] = load_val;
               else if (cnt_reg[gi] != '0)
                  cnt_next[gi] = cnt_reg[gi] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int r = 0; r < NREG; r++)
            cnt_reg[r] <= '0;
         stat_reg <= '0;
      end else begin
         for (int r = 0; r < NREG; r++)
            cnt_reg[r] <= cnt_next[r];
         if (stall && (stat_reg != '1))
            stat_reg <= stat_reg + 1'b1;
      end
   end

   assign bus.Stall      = stall;
   assign bus.Freeze     = bus.MemStall;
   assign bus.StallCount = stat_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed instruction sequences with hand-derived stall expectations. The
// stimulus process pushes one expected record per cycle; a monitor on the
// falling edge pops and compares Stall, Freeze and StallCount. A second
// instance with a 2-bit counter follows the same stream to exercise
// StallCount saturation.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

   logic Clk;
   logic Rst;

   hazard_scoreboard_if #(.REG_ADDR_W(5), .STAT_W(32)) bus ();
   hazard_scoreboard_if #(.REG_ADDR_W(5), .STAT_W(2))  bus2 ();

   hazard_scoreboard #(.STAT_W(32)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus.slave)
   );

   hazard_scoreboard #(.STAT_W(2)) dut_sat (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus2.slave)
   );

   assign bus2.ID_Valid    = bus.ID_Valid;
   assign bus2.ID_rs       = bus.ID_rs;
   assign bus2.ID_rt       = bus.ID_rt;
   assign bus2.ID_UsesRs   = bus.ID_UsesRs;
   assign bus2.ID_UsesRt   = bus.ID_UsesRt;
   assign bus2.ID_Branch   = bus.ID_Branch;
   assign bus2.ID_MemWrite = bus.ID_MemWrite;
   assign bus2.ID_RegWrite = bus.ID_RegWrite;
   assign bus2.ID_MemRead  = bus.ID_MemRead;
   assign bus2.ID_Dest     = bus.ID_Dest;
   assign bus2.Flush       = bus.Flush;
   assign bus2.MemStall    = bus.MemStall;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   typedef struct {
      string       name;
      bit          stall;
      bit          freeze;
      int unsigned cnt;
      int unsigned sat;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cnt_model = 0;
   int unsigned sat_model = 0;

   // One cycle of stimulus plus its expected response.
   task automatic cyc(input string nm, input bit rst, input bit v,
                      input int rs, input int rt, input bit urs, input bit urt,
                      input bit br, input bit mw, input bit rw, input bit mr,
                      input int dest, input bit fl, input bit ms, input bit es);
      exp_t e;
      @(posedge Clk);
      #1;
      Rst             = rst;
      bus.ID_Valid    = v;
      bus.ID_rs       = 5'(rs);
      bus.ID_rt       = 5'(rt);
      bus.ID_UsesRs   = urs;
      bus.ID_UsesRt   = urt;
      bus.ID_Branch   = br;
      bus.ID_MemWrite = mw;
      bus.ID_RegWrite = rw;
      bus.ID_MemRead  = mr;
      bus.ID_Dest     = 5'(dest);
      bus.Flush       = fl;
      bus.MemStall    = ms;
      e.name   = nm;
      e.stall  = es;
      e.freeze = ms;
      e.cnt    = cnt_model;
      e.sat    = sat_model;
      exp_q.push_back(e);
      if (es) begin
         cnt_model++;
         if (sat_model < 3) sat_model++;
      end
      if (rst) begin
         cnt_model = 0;
         sat_model = 0;
      end
   endtask

   task automatic idle(input string nm);
      cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every cycle with a pending expectation is one transaction.
   always @(negedge Clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_checks += 4;
         if (bus.Stall !== e.stall) begin
            n_fail++;
            $display("FAIL %s stall: got %b expected %b", e.name, bus.Stall, e.stall);
         end
         if (bus.Freeze !== e.freeze) begin
            n_fail++;
            $display("FAIL %s freeze: got %b expected %b", e.name, bus.Freeze, e.freeze);
         end
         if (bus.StallCount !== 32'(e.cnt)) begin
            n_fail++;
            $display("FAIL %s count: got %0d expected %0d", e.name, bus.StallCount, e.cnt);
         end
         if (bus2.StallCount !== 2'(e.sat)) begin
            n_fail++;
            $display("FAIL %s satcount: got %0d expected %0d", e.name, bus2.StallCount, e.sat);
         end
         $display("[%0t] %-14s stall=%b freeze=%b count=%0d sat=%0d", $time, e.name,
                  bus.Stall, bus.Freeze, bus.StallCount, bus2.StallCount);
      end
   end

   initial begin
      Rst             = 1'b1;
      bus.ID_Valid    = 1'b0;
      bus.ID_rs       = '0;
      bus.ID_rt       = '0;
      bus.ID_UsesRs   = 1'b0;
      bus.ID_UsesRt   = 1'b0;
      bus.ID_Branch   = 1'b0;
      bus.ID_MemWrite = 1'b0;
      bus.ID_RegWrite = 1'b0;
      bus.ID_MemRead  = 1'b0;
      bus.ID_Dest     = '0;
      bus.Flush       = 1'b0;
      bus.MemStall    = 1'b0;

      //  name             rst v  rs rt urs urt br mw rw mr dst fl ms  stall
      cyc("rst_freeze",     1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("rst_idle",       1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // load -> ALU: one stall cycle
      cyc("lw8",            0, 1, 29, 8, 1, 0, 0, 0, 1, 1, 8, 0, 0, 0);
      cyc("add9_8_2",       0, 1,  8, 2, 1, 1, 0, 0, 1, 0, 9, 0, 0, 1);
      cyc("add9_8_2",       0, 1,  8, 2, 1, 1, 0, 0, 1, 0, 9, 0, 0, 0);
      idle("gap"); idle("gap");

      // load -> branch: two stall cycles
      cyc("lw8",            0, 1, 29, 8, 1, 0, 0, 0, 1, 1, 8, 0, 0, 0);
      cyc("beq8_0",         0, 1,  8, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
      cyc("beq8_0",         0, 1,  8, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
      cyc("beq8_0",         0, 1,  8, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);

      // ALU -> branch: one stall cycle
      cyc("slt16",          0, 1,  4, 5, 1, 1, 0, 0, 1, 0, 16, 0, 0, 0);
      cyc("beq16_17",       0, 1, 16, 17, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
      cyc("beq16_17",       0, 1, 16, 17, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);

      // ALU -> ALU: no stall
      cyc("add20",          0, 1,  4, 5, 1, 1, 0, 0, 1, 0, 20, 0, 0, 0);
      cyc("add21_20",       0, 1, 20, 5, 1, 1, 0, 0, 1, 0, 21, 0, 0, 0);
      idle("gap"); idle("gap");

      // load -> store data: no stall; load -> store base: one stall
      cyc("lw8",            0, 1, 29, 8, 1, 0, 0, 0, 1, 1, 8, 0, 0, 0);
      cyc("sw8_9",          0, 1,  9, 8, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      idle("gap"); idle("gap");
      cyc("lw9",            0, 1, 29, 9, 1, 0, 0, 0, 1, 1, 9, 0, 0, 0);
      cyc("sw8_9",          0, 1,  9, 8, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1);
      cyc("sw8_9",          0, 1,  9, 8, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      idle("gap"); idle("gap");

      // MemStall freezes the scoreboard; stall resumes after release
      cyc("lw8",            0, 1, 29, 8, 1, 0, 0, 0, 1, 1, 8, 0, 0, 0);
      cyc("add_memstall",   0, 1,  8, 2, 1, 1, 0, 0, 1, 0, 9, 0, 1, 0);
      cyc("add_memstall",   0, 1,  8, 2, 1, 1, 0, 0, 1, 0, 9, 0, 1, 0);
      cyc("add_memstall",   0, 1,  8, 2, 1, 1, 0, 0, 1, 0, 9, 0, 1, 0);
      cyc("add_release",    0, 1,  8, 2, 1, 1, 0, 0, 1, 0, 9, 0, 0, 1);
      cyc("add_issue",      0, 1,  8, 2, 1, 1, 0, 0, 1, 0, 9, 0, 0, 0);
      idle("gap"); idle("gap");

      // $0 writes, jumps without sources, flushed slots
      cyc("lw0",            0, 1, 29, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      cyc("beq0_0",         0, 1,  0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("addi0",          0, 1,  1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      cyc("add3_0_0",       0, 1,  0, 0, 1, 1, 0, 0, 1, 0, 3, 0, 0, 0);
      cyc("lw8",            0, 1, 29, 8, 1, 0, 0, 0, 1, 1, 8, 0, 0, 0);
      cyc("jal",            0, 1,  8, 8, 0, 0, 1, 0, 1, 0, 31, 0, 0, 0);
      cyc("beq8_flushed",   0, 1,  8, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
      cyc("lw10_flushed",   0, 1, 29, 10, 1, 0, 0, 0, 1, 1, 10, 1, 0, 0);
      cyc("beq10_0",        0, 1, 10, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      idle("gap"); idle("gap");

      // Later writer reloads: ALU then load to $11, branch sees load latency
      cyc("add11",          0, 1,  1, 2, 1, 1, 0, 0, 1, 0, 11, 0, 0, 0);
      cyc("lw11",           0, 1, 29, 11, 1, 0, 0, 0, 1, 1, 11, 0, 0, 0);
      cyc("beq11_0",        0, 1, 11, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
      cyc("beq11_0",        0, 1, 11, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
      cyc("beq11_0",        0, 1, 11, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      idle("gap"); idle("gap");

      // Reset in the middle of a load -> branch stall
      cyc("lw8",            0, 1, 29, 8, 1, 0, 0, 0, 1, 1, 8, 0, 0, 0);
      cyc("beq8_0",         0, 1,  8, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
      cyc("beq8_rst",       1, 1,  8, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("beq8_after",     0, 1,  8, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      idle("end");

      // Drain outstanding expectations within a fixed budget.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
      @(posedge Clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
